uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Transmit scheduler that lets several requesters share the single UART transmitter, including CPU-side FIFO drain, DMA channel and debug console. It arbitrates round-robin at packet granularity and buffers accepted bytes in a 2-entry holding FIFO. It drives the UART core's `tx_empty`/`tx_rd_data` pair and pops on the core's `uart_tx_ren` strobe. It sits between the requesters and the UART core in the USI block.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `TMO_W`, default 16: width of the lock-timeout counter.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `uart_en`  in  1  UART enable; low flushes and idles the block
- `lock_tmo`  in  TMO_W  idle-cycle limit while locked; 0 disables the timeout
- `req_valid`  in  NREQ  per-requester byte valid
- `req_data`  in  NREQ*8  per-requester byte; requester i uses bits [8i+7:8i]
- `req_last`  in  NREQ  byte is the last of the requester's packet
- `req_ready`  out  NREQ  byte accepted when valid & ready on a clock edge
- `tx_empty`  out  1  to UART core; high when the FIFO holds no byte
- `tx_rd_data`  out  8  to UART core; FIFO head byte
- `uart_tx_ren`  in  1  from UART core; pops the head byte
- `grant_id`  out  $clog2(NREQ)  current or most recent owner
- `busy`  out  1  arbiter locked, or FIFO non-empty
- `pkt_done`  out  1  one-cycle pulse when a `last` byte is accepted
- `pkt_abort`  out  1  one-cycle pulse when a lock is released by timeout or by `uart_en` low
- `ren_err`  out  1  sticky; set by `uart_tx_ren` while the FIFO is empty, cleared only by reset

## Operation
- **FIFO**
  - 2 entries; `cnt` ranges 0..2.
  - `tx_rd_data` is the head entry. It must stay stable from push until pop, because the core samples it throughout DATA and PARITY.
  - Push on accept; pop on `uart_tx_ren & cnt!=0`.
  - Push and pop in the same cycle: `cnt` is unchanged, the new byte goes behind the surviving entry, and the head advances.
  - `tx_empty = (cnt==0)`.
- **Arbiter FSM states**
  - ARB_IDLE:
    - If `uart_en` and `|req_valid`, select the first asserted requester in the order `last_grant+1, last_grant+2, …` mod NREQ.
    - Register it in `grant_id` and move to ARB_LOCK.
  - ARB_LOCK:
    - `req_ready[grant_id] = (cnt<2)`; all other ready bits are 0.
    - Accepting a byte with `req_last`: pulse `pkt_done`, set `last_grant=grant_id`, go to ARB_IDLE.
    - Timeout counter: cleared on every accept and on entry to the state; increments each cycle the granted requester has `req_valid` low.
    - When `lock_tmo!=0` and the counter reaches `lock_tmo`: pulse `pkt_abort`, set `last_grant=grant_id`, go to ARB_IDLE.
    - The counter does not count while `req_valid` is high and the FIFO is full (backpressure is not idleness).
- **Arbiter policy**
  - No requester switch inside a packet.
  - `req_valid` from non-granted requesters is ignored while locked.
  - A single-byte packet (`last` on its first byte) is legal.
- **uart_en low (synchronous)**
  - FIFO flushed (`cnt=0`).
  - FSM returns to ARB_IDLE; `req_ready=0`.
  - `pkt_abort` pulses if the FSM was in ARB_LOCK.
  - `last_grant` is retained.
- **Reset values**
  - FSM ARB_IDLE, `cnt=0`, `tx_empty=1`, `tx_rd_data=0`, `req_ready=0`.
  - `grant_id=0`, `last_grant=NREQ-1` (requester 0 wins first).
  - `busy=0`, `pkt_done=0`, `pkt_abort=0`, `ren_err=0`.

## Timing
- **Arbitration latency:** `req_valid` rises at edge t in ARB_IDLE → `grant_id` and ARB_LOCK are registered at t+1 → `req_ready` is high during cycle t+1 → the first byte is accepted at edge t+2.
- **Push to core:** `tx_empty` falls the cycle after the accepting edge.
- **Pop:** the core pulses `uart_tx_ren` once per frame during the stop bit. The head updates on the next edge. If `cnt` was 2, `tx_empty` stays 0 and the core chains directly into START.
- **Throughput:** one byte per cycle into the FIFO until full; `req_ready` is registered/combinational only from `cnt` and the FSM state.
- **Grant handover:** back-to-back packets from different requesters cost one idle arbitration cycle.
- **Async reset mid-frame:** all state returns to reset values immediately; the core is reset on the same `rst_n`.

## Test plan
- **Single packet, round-robin start:** after reset, req0/req2 valid, req0 bytes 0x55,0xA3(last) → grant 0 first; `tx_empty` low 1 cycle after accept; bytes popped in order by 2 `uart_tx_ren` pulses; `pkt_done` 1 pulse; next grant is 2.
- **Fairness:** all 4 requesters continuously send 1-byte packets → grant order 0,1,2,3,0; no requester is granted twice before the others.
- **FIFO full plus simultaneous push/pop:** hold FIFO at `cnt=2`, drive `uart_tx_ren` while the owner is valid → `req_ready` high that cycle only if `cnt<2`; with `cnt=1` and push+pop together → `cnt` stays 1 and the head equals the new byte.
- **Timeout:** `lock_tmo=10`, req1 sends 1 byte with no last and then drops valid → `pkt_abort` 10 cycles later, FSM in ARB_IDLE, next grant is the next valid requester after 1.
- **Abort on uart_en low:** `uart_en` deasserted with `cnt=2` mid-packet → `cnt=0`, `tx_empty=1`, `pkt_abort` pulse, `req_ready=0` while disabled.
- **Underflow:** `uart_tx_ren` with `cnt=0` → `ren_err` set and held; `cnt` stays 0.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: round-robin, packet-granular arbitration of NREQ byte
// requesters into a 2-entry holding FIFO that feeds the UART core.
module uart_tx_sched #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned TMO_W = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      uart_en,
   input  logic [TMO_W-1:0]          lock_tmo,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*8-1:0]         req_data,
   input  logic [NREQ-1:0]           req_last,
   output logic [NREQ-1:0]           req_ready,
   output logic                      tx_empty,
   output logic [7:0]                tx_rd_data,
   input  logic                      uart_tx_ren,
   output logic [$clog2(NREQ)-1:0]   grant_id,
   output logic                      busy,
   output logic                      pkt_done,
   output logic                      pkt_abort,
   output logic                      ren_err
);

   localparam int unsigned GW = $clog2(NREQ);

   typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCK = 1'b1} arb_state_e;

   arb_state_e       state_q, state_d;
   logic [GW-1:0]    grant_q, grant_d, last_q, last_d, rr_idx, rr_pick;
   logic             rr_found;
   logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
   logic [1:0]       cnt_q, cnt_d;
   logic [7:0]       head_q, head_d, tail_q, tail_d, gdata;
   logic [NREQ-1:0]  ready_q, ready_d;
   logic             gvalid, glast, accept, pop, tmo_hit;
   logic             empty_q, empty_d, busy_q, busy_d;
   logic             done_q, done_d, abort_q, abort_d, err_q, err_d;

   // Request lines of the current owner
   always_comb begin
      gvalid = 1'b0;
      glast  = 1'b0;
      gdata  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_q == GW'(i)) begin
            gvalid = req_valid[i];
            glast  = req_last[i];
            gdata  = req_data[i*8 +: 8];
         end
      end
   end

   // First valid requester after last_grant, wrapping mod NREQ
   always_comb begin
      rr_found = 1'b0;
      rr_pick  = last_q;
      rr_idx   = last_q;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         rr_idx = GW'((32'(last_q) + k) % NREQ);
         if (!rr_found && req_valid[rr_idx]) begin
            rr_found = 1'b1;
            rr_pick  = rr_idx;
         end
      end
   end

   assign accept  = (state_q == ARB_LOCK) && uart_en && gvalid && (|ready_q);
   assign pop     = uart_tx_ren && (cnt_q != 2'd0);
   assign tmo_inc = tmo_q + TMO_W'(1);
   assign tmo_hit = (state_q == ARB_LOCK) && uart_en && !gvalid &&
                    (lock_tmo != '0) && (tmo_inc == lock_tmo);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ARB_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!uart_en) begin
         state_d = ARB_IDLE;
      end else begin
         case (state_q)
            ARB_IDLE: if (rr_found) state_d = ARB_LOCK;
            ARB_LOCK: if ((accept && glast) || tmo_hit) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
         endcase
      end
   end

   // Next values of grant bookkeeping, FIFO and registered outputs
   always_comb begin
      grant_d = grant_q;
      last_d  = last_q;
      tmo_d   = tmo_q;
      cnt_d   = cnt_q;
      head_d  = head_q;
      tail_d  = tail_q;
      ready_d = '0;
      if (state_q == ARB_IDLE && uart_en && rr_found) grant_d = rr_pick;
      if ((accept && glast) || tmo_hit) last_d = grant_q;
      if (state_q == ARB_IDLE || accept) tmo_d = '0;
      else if (!gvalid)                 tmo_d = tmo_inc;
      if (!uart_en) begin
         cnt_d = 2'd0;
      end else begin
         if (pop) begin
            head_d = tail_q;
            cnt_d  = cnt_q - 2'd1;
         end
         // New byte lands behind whatever survives this cycle's pop
         if (accept) begin
            if (cnt_d == 2'd0) head_d = gdata;
            else               tail_d = gdata;
            cnt_d = cnt_d + 2'd1;
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         ready_d[i] = (state_d == ARB_LOCK) && (cnt_d != 2'd2) && (grant_d == GW'(i));
      end
      empty_d = (cnt_d == 2'd0);
      busy_d  = (state_d == ARB_LOCK) || (cnt_d != 2'd0);
      done_d  = accept && glast;
      abort_d = tmo_hit || (!uart_en && state_q == ARB_LOCK);
      err_d   = err_q || (uart_tx_ren && cnt_q == 2'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q <= '0;
         last_q  <= GW'(NREQ - 1);
         tmo_q   <= '0;
         cnt_q   <= 2'd0;
         head_q  <= 8'h00;
         tail_q  <= 8'h00;
         ready_q <= '0;
         empty_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         grant_q <= grant_d;
         last_q  <= last_d;
         tmo_q   <= tmo_d;
         cnt_q   <= cnt_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         ready_q <= ready_d;
         empty_q <= empty_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         abort_q <= abort_d;
         err_q   <= err_d;
      end
   end

   assign req_ready  = ready_q & {NREQ{uart_en}};
   assign tx_empty   = empty_q;
   assign tx_rd_data = head_q;
   assign grant_id   = grant_q;
   assign busy       = busy_q;
   assign pkt_done   = done_q;
   assign pkt_abort  = abort_q;
   assign ren_err    = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched (NREQ=4).
module tb_uart_tx_sched;

   logic        clk;
   logic        rst_n;
   logic        uart_en;
   logic [15:0] lock_tmo;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        tx_empty;
   logic [7:0]  tx_rd_data;
   logic        uart_tx_ren;
   logic [1:0]  grant_id;
   logic        busy;
   logic        pkt_done;
   logic        pkt_abort;
   logic        ren_err;

   int n_checks = 0;
   int n_errors = 0;

   uart_tx_sched #(.NREQ(4), .TMO_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .uart_en     (uart_en),
      .lock_tmo    (lock_tmo),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_empty    (tx_empty),
      .tx_rd_data  (tx_rd_data),
      .uart_tx_ren (uart_tx_ren),
      .grant_id    (grant_id),
      .busy        (busy),
      .pkt_done    (pkt_done),
      .pkt_abort   (pkt_abort),
      .ren_err     (ren_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      uart_en     = 1'b1;
      lock_tmo    = 16'd0;
      req_valid   = 4'b0000;
      req_data    = 32'h0;
      req_last    = 4'b0000;
      uart_tx_ren = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int         got_n;
      logic [1:0] got_g [5];

      // Reset values, sampled while rst_n is still low
      rst_n = 1'b0; uart_en = 1'b1; lock_tmo = 16'd0; req_valid = '0;
      req_data = '0; req_last = '0; uart_tx_ren = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tx_empty",  32'(tx_empty),   32'd1);
      chk("rst_rd_data",   32'(tx_rd_data), 32'h00);
      chk("rst_req_ready", 32'(req_ready),  32'h0);
      chk("rst_grant",     32'(grant_id),   32'd0);
      chk("rst_busy",      32'(busy),       32'd0);
      chk("rst_done",      32'(pkt_done),   32'd0);
      chk("rst_abort",     32'(pkt_abort),  32'd0);
      chk("rst_ren_err",   32'(ren_err),    32'd0);
      rst_n = 1'b1;

      // Single packet: req0 wins first, then req2 next
      req_valid = 4'b0101;
      req_data[7:0] = 8'h55; req_data[23:16] = 8'h77;
      req_last = 4'b0100;
      step();
      chk("sp_grant0",  32'(grant_id),  32'd0);
      chk("sp_ready0",  32'(req_ready), 32'b0001);
      chk("sp_empty0",  32'(tx_empty),  32'd1);
      step();
      chk("sp_empty_fall", 32'(tx_empty),   32'd0);
      chk("sp_head55",     32'(tx_rd_data), 32'h55);
      chk("sp_done_lo",    32'(pkt_done),   32'd0);
      req_data[7:0] = 8'hA3; req_last = 4'b0101;
      step();
      chk("sp_done",      32'(pkt_done),   32'd1);
      chk("sp_head_keep", 32'(tx_rd_data), 32'h55);
      chk("sp_ready_idle", 32'(req_ready), 32'h0);
      chk("sp_busy",      32'(busy),       32'd1);
      req_valid = 4'b0100;
      step();
      chk("sp_grant2",    32'(grant_id),  32'd2);
      chk("sp_done_pulse", 32'(pkt_done), 32'd0);
      chk("sp_full_ready", 32'(req_ready), 32'h0);
      uart_tx_ren = 1'b1;
      step();
      uart_tx_ren = 1'b0;
      chk("sp_headA3",   32'(tx_rd_data), 32'hA3);
      chk("sp_ready2",   32'(req_ready),  32'b0100);
      step();
      chk("sp_done2",    32'(pkt_done),   32'd1);
      req_valid = 4'b0000;
      uart_tx_ren = 1'b1;
      step();
      chk("sp_head77",   32'(tx_rd_data), 32'h77);
      step();
      uart_tx_ren = 1'b0;
      chk("sp_drained",  32'(tx_empty),   32'd1);
      chk("sp_busy_lo",  32'(busy),       32'd0);
      chk("sp_no_err",   32'(ren_err),    32'd0);

      // Fairness: all four send 1-byte packets, core drains continuously
      do_reset();
      req_valid = 4'b1111;
      req_last  = 4'b1111;
      req_data  = 32'h13121110;
      got_n = 0;
      for (int c = 0; c < 40 && got_n < 5; c++) begin
         step();
         if (pkt_done) begin
            got_g[got_n] = grant_id;
            got_n++;
            if (got_n == 5) req_valid = 4'b0000;
         end
         uart_tx_ren = !tx_empty;
      end
      chk("fair_count", 32'(got_n), 32'd5);
      for (int i = 0; i < 5; i++) chk("fair_grant", 32'(got_g[i]), 32'(i % 4));
      for (int c = 0; c < 4; c++) begin
         uart_tx_ren = !tx_empty;
         step();
      end
      uart_tx_ren = 1'b0;
      chk("fair_empty", 32'(tx_empty), 32'd1);
      chk("fair_no_err", 32'(ren_err), 32'd0);

      // FIFO full, then push+pop at cnt=1 (last_grant is 0, so req1 wins)
      req_valid = 4'b0010; req_last = 4'b0000; req_data[15:8] = 8'hB1;
      step();
      chk("ff_grant1", 32'(grant_id),  32'd1);
      chk("ff_ready1", 32'(req_ready), 32'b0010);
      step();
      chk("ff_headB1", 32'(tx_rd_data), 32'hB1);
      req_data[15:8] = 8'hB2;
      step();
      chk("ff_full_ready", 32'(req_ready), 32'h0);
      req_data[15:8] = 8'hB3; req_last = 4'b0010;
      step();
      chk("ff_hold_ready", 32'(req_ready),  32'h0);
      chk("ff_hold_head",  32'(tx_rd_data), 32'hB1);
      uart_tx_ren = 1'b1;
      step();
      chk("ff_pop_head",  32'(tx_rd_data), 32'hB2);
      chk("ff_pop_ready", 32'(req_ready),  32'b0010);
      step();
      chk("ff_pp_head",  32'(tx_rd_data), 32'hB3);
      chk("ff_pp_empty", 32'(tx_empty),   32'd0);
      chk("ff_pp_done",  32'(pkt_done),   32'd1);
      req_valid = 4'b0000;
      step();
      uart_tx_ren = 1'b0;
      chk("ff_pp_cnt1", 32'(tx_empty), 32'd1);

      // Timeout: req1 sends one byte then idles; req3 waits meanwhile
      lock_tmo = 16'd10;
      req_valid = 4'b0010; req_last = 4'b0000; req_data[15:8] = 8'hC1;
      step();
      chk("to_grant1", 32'(grant_id), 32'd1);
      step();
      chk("to_headC1", 32'(tx_rd_data), 32'hC1);
      req_valid = 4'b1000; req_data[31:24] = 8'hD3; req_last = 4'b1000;
      for (int k = 1; k <= 9; k++) begin
         step();
         chk("to_early", 32'(pkt_abort), 32'd0);
         if (k == 1) chk("to_ignore3", 32'(req_ready), 32'b0010);
      end
      step();
      chk("to_abort",      32'(pkt_abort), 32'd1);
      chk("to_idle_ready", 32'(req_ready), 32'h0);
      step();
      chk("to_grant3",   32'(grant_id),  32'd3);
      chk("to_abort_lo", 32'(pkt_abort), 32'd0);
      chk("to_ready3",   32'(req_ready), 32'b1000);
      step();
      chk("to_done3", 32'(pkt_done), 32'd1);

      // uart_en low with cnt=2 while locked mid-packet on req0
      lock_tmo = 16'd0;
      req_valid = 4'b0001; req_data[7:0] = 8'hE0; req_last = 4'b0000;
      step();
      chk("en_grant0",  32'(grant_id),  32'd0);
      chk("en_full",    32'(req_ready), 32'h0);
      chk("en_busy",    32'(busy),      32'd1);
      uart_en = 1'b0;
      req_valid = 4'b0011;
      step();
      chk("en_flush_empty", 32'(tx_empty),  32'd1);
      chk("en_abort",       32'(pkt_abort), 32'd1);
      chk("en_ready_off",   32'(req_ready), 32'h0);
      chk("en_busy_lo",     32'(busy),      32'd0);
      step();
      chk("en_abort_pulse", 32'(pkt_abort), 32'd0);
      chk("en_ready_off2",  32'(req_ready), 32'h0);
      uart_en = 1'b1;
      step();
      chk("en_last_kept", 32'(grant_id), 32'd0);
      req_valid = 4'b0000;

      // Underflow: pop request with nothing buffered
      uart_tx_ren = 1'b1;
      step();
      uart_tx_ren = 1'b0;
      chk("uf_err",   32'(ren_err),  32'd1);
      chk("uf_empty", 32'(tx_empty), 32'd1);
      step();
      chk("uf_sticky", 32'(ren_err),  32'd1);
      chk("uf_empty2", 32'(tx_empty), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
